// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared constants for the multi-cycle RISC-V control unit.
// Holds the ALU control encodings ({ainvert, bnegate, operation[1:0]}), the
// opcode/funct3/funct7 values the controller recognises, the FSM state enum,
// the ALU opclass used by the ALU-control decoder, and datapath mux selects.
package riscv_pkg;

  // ALU control encodings
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Opcodes
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // funct3 / funct7 values
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LSW = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Mux selects
  localparam logic [1:0] SRCA_PC     = 2'd0;
  localparam logic [1:0] SRCA_RS1    = 2'd1;
  localparam logic [1:0] SRCA_OLDPC  = 2'd2;
  localparam logic [1:0] SRCB_RS2    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic       PCSRC_ALU    = 1'b0;
  localparam logic       PCSRC_ALUOUT = 1'b1;
  localparam logic       ADDR_PC      = 1'b0;
  localparam logic       ADDR_ALUOUT  = 1'b1;
  localparam logic       WB_ALUOUT    = 1'b0;
  localparam logic       WB_MDR       = 1'b1;

  // Instruction class seen by the ALU-control decoder
  typedef enum logic {
    CLS_R = 1'b0,
    CLS_I = 1'b1
  } opclass_e;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_ALU_WB   = 4'd4,
    ST_MEM_ADDR = 4'd5,
    ST_MEM_RD   = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_TRAP     = 4'd10
  } state_e;

endpackage

// File: rtl/riscv_alu_ctrl_dec.sv
// riscv_alu_ctrl_dec -- combinational ALU-control decoder.
// Ports:
//   i_opclass  : CLS_R (register-register) or CLS_I (register-immediate)
//   i_funct3   : instr[14:12]
//   i_funct7   : instr[31:25] (ignored for CLS_I, where it is immediate)
//   o_alu_ctrl : ALU operation {ainvert, bnegate, operation[1:0]}
//   o_legal    : 1 when the opclass/funct combination is supported
module riscv_alu_ctrl_dec
  import riscv_pkg::*;
(
  input  opclass_e   i_opclass,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output logic [3:0] o_alu_ctrl,
  output logic       o_legal
);

  logic w_f7_base;
  assign w_f7_base = (i_opclass == CLS_I) || (i_funct7 == F7_BASE);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_legal    = 1'b0;
    case (i_funct3)
      F3_ADD: begin
        if (w_f7_base) begin
          o_alu_ctrl = ALU_ADD;
          o_legal    = 1'b1;
        end else if (i_funct7 == F7_ALT) begin
          // only the R-type form reaches here: SUB
          o_alu_ctrl = ALU_SUB;
          o_legal    = 1'b1;
        end
      end
      F3_AND: begin
        o_alu_ctrl = ALU_AND;
        o_legal    = w_f7_base;
      end
      F3_OR: begin
        o_alu_ctrl = ALU_OR;
        o_legal    = w_f7_base;
      end
      F3_SLT: begin
        o_alu_ctrl = ALU_SLT;
        o_legal    = w_f7_base;
      end
      default: begin
        o_alu_ctrl = ALU_ADD;
        o_legal    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl -- multi-cycle RISC-V control FSM (R/I ALU ops, lw, sw, beq).
// Inputs : clk, rst (async, active high), instr (IR), alu_zero, mem_ready.
// Outputs: alu_ctrl, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
//          mem_req, mem_we, addr_sel, reg_write, wb_sel, illegal,
//          mem_timeout, dbg_state (current FSM state for observation).
// Build option: RISCV_MC_CTRL_TRAP_EN -- when defined, an illegal instruction
// parks the FSM in TRAP (illegal held high) until reset; otherwise illegal
// pulses for one DECODE cycle and the instruction retires as a NOP.
// Handshake: a memory request (mem_req) completes in any cycle where
// mem_ready=1; the request is abandoned once it has waited MEM_WAIT_MAX cycles.
module riscv_mc_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        pc_src,
  output logic        ir_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        reg_write,
  output logic        wb_sel,
  output logic        illegal,
  output logic        mem_timeout,
  output logic [3:0]  dbg_state
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  state_e         r_state;
  state_e         w_next;
  logic [CW-1:0]  r_wait_cnt;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_instr_bits;
  opclass_e   w_opclass;
  logic [3:0] w_dec_alu_ctrl;
  logic       w_dec_legal;
  logic       w_legal;
  logic       w_wait_done;

  logic       w_pc_write, w_ir_write, w_mem_req, w_mem_we, w_reg_write;
  logic       w_illegal, w_timeout;

  assign w_opcode  = instr[6:0];
  assign w_funct3  = instr[14:12];
  assign w_funct7  = instr[31:25];
  assign w_unused_instr_bits = ^{instr[24:15], instr[11:7]};
  assign w_opclass = (w_opcode == OP_R) ? CLS_R : CLS_I;

  riscv_alu_ctrl_dec u_dec (
    .i_opclass  (w_opclass),
    .i_funct3   (w_funct3),
    .i_funct7   (w_funct7),
    .o_alu_ctrl (w_dec_alu_ctrl),
    .o_legal    (w_dec_legal)
  );

  always_comb begin
    w_legal = 1'b0;
    case (w_opcode)
      OP_R, OP_I:   w_legal = w_dec_legal;
      OP_LW, OP_SW: w_legal = (w_funct3 == F3_LSW);
      OP_BR:        w_legal = (w_funct3 == F3_BEQ);
      default:      w_legal = 1'b0;
    endcase
  end

  assign w_wait_done = (r_wait_cnt == CW'(MEM_WAIT_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_next;
  end

  // Wait counter restarts on completion, abandonment or any state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_wait_cnt <= '0;
    else if (mem_ready || w_timeout || (w_next != r_state))
      r_wait_cnt <= '0;
    else if (w_mem_req)
      r_wait_cnt <= r_wait_cnt + CW'(1);
  end

  always_comb begin
    w_next      = r_state;
    alu_ctrl    = 4'b0000;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    pc_src      = 1'b0;
    addr_sel    = 1'b0;
    wb_sel      = 1'b0;
    w_pc_write  = 1'b0;
    w_ir_write  = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_reg_write = 1'b0;
    w_illegal   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        addr_sel  = ADDR_PC;
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALU_ADD;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          pc_src     = PCSRC_ALU;
          w_next     = ST_DECODE;
        end else if (w_wait_done) begin
          w_timeout = 1'b1;
          w_next    = ST_FETCH;
        end
      end
      ST_DECODE: begin
        // ALU speculatively forms the branch target from oldPC + imm
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        if (!w_legal) begin
          w_illegal = 1'b1;
`ifdef RISCV_MC_CTRL_TRAP_EN
          w_next = ST_TRAP;
`else
          w_next = ST_FETCH;
`endif
        end else begin
          case (w_opcode)
            OP_R:         w_next = ST_EXEC_R;
            OP_I:         w_next = ST_EXEC_I;
            OP_LW, OP_SW: w_next = ST_MEM_ADDR;
            OP_BR:        w_next = ST_BRANCH;
            default:      w_next = ST_FETCH;
          endcase
        end
      end
      ST_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_ctrl  = w_dec_alu_ctrl;
        w_next    = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = w_dec_alu_ctrl;
        w_next    = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        w_reg_write = 1'b1;
        wb_sel      = WB_ALUOUT;
        w_next      = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
        w_next    = (w_opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        w_mem_req = 1'b1;
        addr_sel  = ADDR_ALUOUT;
        if (mem_ready)        w_next = ST_MEM_WB;
        else if (w_wait_done) begin
          w_timeout = 1'b1;
          w_next    = ST_FETCH;
        end
      end
      ST_MEM_WB: begin
        w_reg_write = 1'b1;
        wb_sel      = WB_MDR;
        w_next      = ST_FETCH;
      end
      ST_MEM_WR: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
        addr_sel  = ADDR_ALUOUT;
        if (mem_ready)        w_next = ST_FETCH;
        else if (w_wait_done) begin
          w_timeout = 1'b1;
          w_next    = ST_FETCH;
        end
      end
      ST_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_ctrl   = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
        w_pc_write = alu_zero;
        w_next     = ST_FETCH;
      end
      ST_TRAP: begin
`ifdef RISCV_MC_CTRL_TRAP_EN
        w_illegal = 1'b1;
        w_next    = ST_TRAP;
`else
        w_next    = ST_FETCH;
`endif
      end
      default: w_next = ST_FETCH;
    endcase
  end

  // Strobes are held low for the whole time reset is asserted.
  assign pc_write    = w_pc_write  & ~rst;
  assign ir_write    = w_ir_write  & ~rst;
  assign mem_req     = w_mem_req   & ~rst;
  assign mem_we      = w_mem_we    & ~rst;
  assign reg_write   = w_reg_write & ~rst;
  assign illegal     = w_illegal   & ~rst;
  assign mem_timeout = w_timeout   & ~rst;
  assign dbg_state   = r_state;

endmodule
